dds_sweep_gen: RTL and testbench

Parametrised frequency-sweep sequencer that drives the phase-increment config port of the DDS core.
Successor to the fixed LFM burst controller. It adds:
- runtime start/stop/step values
- up, down and triangle sweep modes
- per-step dwell time
- sweep repeat count, including continuous mode
- abort
- AXI-stream style valid/ready on the config output
It sits between the control/button logic and the DDS compiler's s_axis_config port.

---
 rtl/dds_sweep_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_dds_sweep_gen.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_gen.sv
// Frequency-sweep sequencer feeding phase-increment words to the DDS s_axis_config port.
// Optional macro SWEEP_SATURATE_EN: an overshooting leg emits its bound as an extra final word.
module dds_sweep_gen #(
    parameter int PINC_W  = 32,
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [1:0]         i_mode,
    input  logic [PINC_W-1:0]  i_start_freq,
    input  logic [PINC_W-1:0]  i_stop_freq,
    input  logic [PINC_W-1:0]  i_step_freq,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [CNT_W-1:0]   i_repeat,
    output logic [PINC_W-1:0]  o_cfg_tdata,
    output logic               o_cfg_tvalid,
    input  logic               i_cfg_tready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [CNT_W-1:0]   o_step_idx,
    output logic [CNT_W-1:0]   o_sweep_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EMIT  = 3'd2,
        ST_DWELL = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

`ifdef SWEEP_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    state_t             state_r, state_s;
    logic [1:0]         mode_r, mode_s;
    logic [PINC_W-1:0]  lo_r, lo_s, hi_r, hi_s, step_r, step_s, cur_r, cur_s;
    logic [DWELL_W-1:0] dwell_r, dwell_s, dwell_cnt_r, dwell_cnt_s;
    logic [CNT_W-1:0]   repeat_r, repeat_s, idx_r, idx_s, sweep_cnt_r, sweep_cnt_s;
    logic               falling_r, falling_s;
    logic               tvalid_r, tvalid_s, busy_r, busy_s, done_r, done_s, err_r, err_s;

    logic [PINC_W:0]    up_sum_s, lo_plus_step_s;
    logic [CNT_W:0]     cnt_inc_s;
    logic               is_down_s, is_tri_s;
    logic               rise_ok_s, fall_ok_s, rise_go_s, fall_go_s;
    logic [PINC_W-1:0]  rise_val_s, fall_val_s;

    // Step arithmetic is one bit wider than the words so a sum never wraps past the bound.
    assign up_sum_s       = {1'b0, cur_r} + {1'b0, step_r};
    assign lo_plus_step_s = {1'b0, lo_r} + {1'b0, step_r};
    assign cnt_inc_s      = {1'b0, sweep_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign is_down_s      = (mode_r == 2'd1);
    assign is_tri_s       = (mode_r == 2'd2);
    assign rise_ok_s      = (up_sum_s <= {1'b0, hi_r});
    assign fall_ok_s      = ({1'b0, cur_r} >= lo_plus_step_s);
    assign rise_go_s      = rise_ok_s || (SAT && (cur_r != hi_r));
    assign fall_go_s      = fall_ok_s || (SAT && (cur_r != lo_r));
    assign rise_val_s     = rise_ok_s ? up_sum_s[PINC_W-1:0] : hi_r;
    assign fall_val_s     = fall_ok_s ? (cur_r - step_r) : lo_r;

    // Next-state and next-output logic; abort outside IDLE overrides every other decision.
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        lo_s        = lo_r;
        hi_s        = hi_r;
        step_s      = step_r;
        dwell_s     = dwell_r;
        repeat_s    = repeat_r;
        cur_s       = cur_r;
        falling_s   = falling_r;
        dwell_cnt_s = dwell_cnt_r;
        idx_s       = idx_r;
        sweep_cnt_s = sweep_cnt_r;
        busy_s      = busy_r;
        tvalid_s    = 1'b0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        if (i_abort && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        mode_s   = i_mode;
                        lo_s     = i_start_freq;
                        hi_s     = i_stop_freq;
                        step_s   = i_step_freq;
                        dwell_s  = i_dwell;
                        repeat_s = i_repeat;
                        if ((i_start_freq > i_stop_freq) || (i_step_freq == {PINC_W{1'b0}})) begin
                            err_s = 1'b1;
                        end else begin
                            sweep_cnt_s = {CNT_W{1'b0}};
                            busy_s      = 1'b1;
                            state_s     = ST_LOAD;
                        end
                    end else begin
                        busy_s = 1'b0;
                    end
                end
                ST_LOAD: begin
                    cur_s     = is_down_s ? hi_r : lo_r;
                    falling_s = is_down_s;
                    idx_s     = {CNT_W{1'b0}};
                    busy_s    = 1'b1;
                    tvalid_s  = 1'b1;
                    state_s   = ST_EMIT;
                end
                ST_EMIT: begin
                    if (i_cfg_tready) begin
                        dwell_cnt_s = dwell_r;
                        if (dwell_r == {DWELL_W{1'b0}}) begin
                            state_s = ST_NEXT;
                        end else begin
                            state_s = ST_DWELL;
                        end
                    end else begin
                        tvalid_s = 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (dwell_cnt_r <= {{(DWELL_W-1){1'b0}}, 1'b1}) begin
                        state_s = ST_NEXT;
                    end else begin
                        dwell_cnt_s = dwell_cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_NEXT: begin
                    idx_s = idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    // A triangle whose rising leg is exhausted continues downward from the peak.
                    if (!falling_r && rise_go_s) begin
                        cur_s    = rise_val_s;
                        tvalid_s = 1'b1;
                        state_s  = ST_EMIT;
                    end else if ((falling_r || is_tri_s) && fall_go_s) begin
                        cur_s     = fall_val_s;
                        falling_s = 1'b1;
                        tvalid_s  = 1'b1;
                        state_s   = ST_EMIT;
                    end else begin
                        sweep_cnt_s = cnt_inc_s[CNT_W-1:0];
                        if ((repeat_r == {CNT_W{1'b0}}) || (cnt_inc_s < {1'b0, repeat_r})) begin
                            state_s = ST_LOAD;
                        end else begin
                            done_s  = 1'b1;
                            busy_s  = 1'b0;
                            state_s = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end
                default: begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'd0;
            lo_r        <= {PINC_W{1'b0}};
            hi_r        <= {PINC_W{1'b0}};
            step_r      <= {PINC_W{1'b0}};
            cur_r       <= {PINC_W{1'b0}};
            dwell_r     <= {DWELL_W{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
            repeat_r    <= {CNT_W{1'b0}};
            idx_r       <= {CNT_W{1'b0}};
            sweep_cnt_r <= {CNT_W{1'b0}};
            falling_r   <= 1'b0;
            tvalid_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            lo_r        <= lo_s;
            hi_r        <= hi_s;
            step_r      <= step_s;
            cur_r       <= cur_s;
            dwell_r     <= dwell_s;
            dwell_cnt_r <= dwell_cnt_s;
            repeat_r    <= repeat_s;
            idx_r       <= idx_s;
            sweep_cnt_r <= sweep_cnt_s;
            falling_r   <= falling_s;
            tvalid_r    <= tvalid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign o_cfg_tdata  = cur_r;
    assign o_cfg_tvalid = tvalid_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_err        = err_r;
    assign o_step_idx   = idx_r;
    assign o_sweep_cnt  = sweep_cnt_r;

endmodule

// File: tb/tb_dds_sweep_gen.sv
// Self-checking bench for dds_sweep_gen: directed and randomized sweeps against a list-building model.
// Honours SWEEP_SATURATE_EN in its model when the design is built with it.
module tb_dds_sweep_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_abort, i_cfg_tready;
    logic [1:0]  i_mode;
    logic [31:0] i_start_freq, i_stop_freq, i_step_freq;
    logic [15:0] i_dwell, i_repeat;
    logic [31:0] o_cfg_tdata;
    logic        o_cfg_tvalid, o_busy, o_done, o_err;
    logic [15:0] o_step_idx, o_sweep_cnt;

    always #5 clk = ~clk;

    dds_sweep_gen #(.PINC_W(32), .DWELL_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_mode(i_mode),
        .i_start_freq(i_start_freq), .i_stop_freq(i_stop_freq), .i_step_freq(i_step_freq),
        .i_dwell(i_dwell), .i_repeat(i_repeat), .o_cfg_tdata(o_cfg_tdata),
        .o_cfg_tvalid(o_cfg_tvalid), .i_cfg_tready(i_cfg_tready), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err), .o_step_idx(o_step_idx), .o_sweep_cnt(o_sweep_cnt)
    );

    int errors = 0;
    int checks = 0;
    longint exp_q[$];
    int     exp_idx_q[$];
    longint obs_q[$];
    int     obs_idx_q[$];
    int     obs_k_q[$];
    int     done_cnt, err_cnt, stable_bad, first_valid, extra_valid;
    bit     timed_out;

    // Reference: list the words of one sweep directly from the range rules, then repeat it.
    task automatic build_expected(input int mode, input longint lo, input longint hi,
                                  input longint step, input int reps);
        longint leg[$];
        longint v;
        exp_q.delete();
        exp_idx_q.delete();
        if (mode == 1) begin
            for (v = hi; v >= lo; v = v - step) leg.push_back(v);
`ifdef SWEEP_SATURATE_EN
            if (leg[$] != lo) leg.push_back(lo);
`endif
        end else begin
            for (v = lo; v <= hi; v = v + step) leg.push_back(v);
`ifdef SWEEP_SATURATE_EN
            if (leg[$] != hi) leg.push_back(hi);
`endif
            if (mode == 2) begin
                for (v = leg[$] - step; v >= lo; v = v - step) leg.push_back(v);
`ifdef SWEEP_SATURATE_EN
                if (leg[$] != lo) leg.push_back(lo);
`endif
            end
        end
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < leg.size(); i++) begin
                exp_q.push_back(leg[i]);
                exp_idx_q.push_back(i);
            end
        end
    endtask

    // Start a run and record every accepted word until o_done (bounded by budget cycles).
    task automatic run_sweep(input logic [1:0] mode, input logic [31:0] lo, input logic [31:0] hi,
                             input logic [31:0] step, input logic [15:0] dwell,
                             input logic [15:0] rep, input bit bp, input int budget);
        int k, low_cnt;
        bit pend;
        logic [31:0] pend_data;
        obs_q.delete(); obs_idx_q.delete(); obs_k_q.delete();
        done_cnt = 0; err_cnt = 0; stable_bad = 0; first_valid = -1; extra_valid = 0;
        timed_out = 1'b1;
        k = 0; low_cnt = 0; pend = 1'b0; pend_data = 32'd0;
        @(negedge clk);
        i_mode = mode; i_start_freq = lo; i_stop_freq = hi; i_step_freq = step;
        i_dwell = dwell; i_repeat = rep; i_cfg_tready = !bp; i_start = 1'b1;
        while (k < budget) begin
            @(negedge clk);
            k++;
            i_start = 1'b0;
            if (o_err) err_cnt++;
            if (o_done) begin
                done_cnt++;
                timed_out = 1'b0;
                break;
            end
            if (o_cfg_tvalid) begin
                if (first_valid < 0) first_valid = k;
                if (pend && (o_cfg_tdata !== pend_data)) stable_bad++;
                if (bp && (low_cnt < 5)) begin
                    i_cfg_tready = 1'b0;
                    low_cnt++;
                end else begin
                    i_cfg_tready = 1'b1;
                    low_cnt = 0;
                end
                if (i_cfg_tready) begin
                    obs_q.push_back(o_cfg_tdata);
                    obs_idx_q.push_back(o_step_idx);
                    obs_k_q.push_back(k);
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    pend_data = o_cfg_tdata;
                end
            end else begin
                i_cfg_tready = !bp;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (o_done) done_cnt++;
            if (o_cfg_tvalid) extra_valid++;
        end
        i_cfg_tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_cfg_tready = 1'b1; i_mode = 2'd0;
        i_start_freq = 32'd0; i_stop_freq = 32'd0; i_step_freq = 32'd0; i_dwell = 16'd0; i_repeat = 16'd0;
        repeat (3) @(negedge clk);
        checks++; if (o_cfg_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", o_cfg_tvalid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: done %b err %b expected 0 0", o_done, o_err); end
        checks++; if (o_cfg_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata: got %0d expected 0", o_cfg_tdata); end
        checks++; if (o_step_idx !== 16'd0 || o_sweep_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts: idx %0d cnt %0d expected 0 0", o_step_idx, o_sweep_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_basic_up();
        run_sweep(2'd0, 32'd100, 32'd130, 32'd10, 16'd2, 16'd1, 1'b0, 200);
        build_expected(0, 100, 130, 10, 1);
        checks++; if (timed_out) begin errors++; $display("FAIL up_timeout: no o_done within budget"); end
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL up_count: got %0d words expected 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL up_word%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (first_valid != 2) begin errors++; $display("FAIL up_latency: first tvalid at cycle %0d expected 2", first_valid); end
        for (int i = 1; i < obs_k_q.size(); i++) begin
            checks++; if (obs_k_q[i] - obs_k_q[i-1] != 4) begin errors++; $display("FAIL up_period%0d: got %0d expected 4", i, obs_k_q[i] - obs_k_q[i-1]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL up_done: got %0d pulses expected 1", done_cnt); end
        checks++; if (o_sweep_cnt !== 16'd1) begin errors++; $display("FAIL up_sweep_cnt: got %0d expected 1", o_sweep_cnt); end
        checks++; if (o_busy !== 1'b0 || extra_valid != 0) begin errors++; $display("FAIL up_idle: busy %b tvalid cycles %0d expected 0 0", o_busy, extra_valid); end
    endtask

    task automatic test_overshoot();
        int n_exp;
`ifdef SWEEP_SATURATE_EN
        n_exp = 4;
`else
        n_exp = 3;
`endif
        run_sweep(2'd0, 32'd100, 32'd125, 32'd10, 16'd1, 16'd1, 1'b0, 200);
        build_expected(0, 100, 125, 10, 1);
        checks++; if (timed_out) begin errors++; $display("FAIL over_timeout: no o_done within budget"); end
        checks++; if (obs_q.size() != n_exp) begin errors++; $display("FAIL over_count: got %0d words expected %0d", obs_q.size(), n_exp); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL over_word%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_triangle();
        run_sweep(2'd2, 32'd100, 32'd130, 32'd10, 16'd0, 16'd1, 1'b0, 200);
        build_expected(2, 100, 130, 10, 1);
        checks++; if (timed_out) begin errors++; $display("FAIL tri_timeout: no o_done within budget"); end
        checks++; if (obs_q.size() != 7) begin errors++; $display("FAIL tri_count: got %0d words expected 7", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL tri_word%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
            checks++; if (obs_idx_q[i] != i) begin errors++; $display("FAIL tri_idx%0d: got %0d expected %0d", i, obs_idx_q[i], i); end
        end
        for (int i = 1; i < obs_k_q.size(); i++) begin
            checks++; if (obs_k_q[i] - obs_k_q[i-1] != 2) begin errors++; $display("FAIL tri_period%0d: got %0d expected 2", i, obs_k_q[i] - obs_k_q[i-1]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL tri_done: got %0d pulses expected 1", done_cnt); end
    endtask

    task automatic test_backpressure_repeat();
        run_sweep(2'd1, 32'd100, 32'd130, 32'd15, 16'd1, 16'd2, 1'b1, 400);
        build_expected(1, 100, 130, 15, 2);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: no o_done within budget"); end
        checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d words expected 6", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (stable_bad != 0) begin errors++; $display("FAIL bp_stable: tdata changed %0d times while stalled, expected 0", stable_bad); end
        checks++; if (o_sweep_cnt !== 16'd2) begin errors++; $display("FAIL bp_sweep_cnt: got %0d expected 2", o_sweep_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", done_cnt); end
    endtask

    task automatic test_reject();
        logic [31:0] lo_v[2];
        logic [31:0] hi_v[2];
        logic [31:0] st_v[2];
        lo_v[0] = 32'd200; hi_v[0] = 32'd100; st_v[0] = 32'd10;
        lo_v[1] = 32'd100; hi_v[1] = 32'd200; st_v[1] = 32'd0;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            i_mode = 2'd0; i_start_freq = lo_v[t]; i_stop_freq = hi_v[t]; i_step_freq = st_v[t];
            i_dwell = 16'd0; i_repeat = 16'd1; i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL rej%0d_err: got %b expected 1", t, o_err); end
            checks++; if (o_busy !== 1'b0 || o_cfg_tvalid !== 1'b0) begin errors++; $display("FAIL rej%0d_idle: busy %b tvalid %b expected 0 0", t, o_busy, o_cfg_tvalid); end
            extra_valid = 0;
            repeat (4) begin
                @(negedge clk);
                if (o_cfg_tvalid || o_busy || o_err) extra_valid++;
            end
            checks++; if (extra_valid != 0) begin errors++; $display("FAIL rej%0d_quiet: %0d active cycles expected 0", t, extra_valid); end
        end
    endtask

    task automatic test_abort();
        int k;
        bit found, prev_valid;
        int bad;
        @(negedge clk);
        i_mode = 2'd0; i_start_freq = 32'd100; i_stop_freq = 32'd130; i_step_freq = 32'd10;
        i_dwell = 16'd3; i_repeat = 16'd0; i_cfg_tready = 1'b1; i_start = 1'b1;
        k = 0; found = 1'b0; prev_valid = 1'b0;
        while (k < 2000 && !found) begin
            @(negedge clk);
            k++;
            i_start = 1'b0;
            if (o_sweep_cnt == 16'd2 && o_busy && !o_cfg_tvalid && prev_valid) found = 1'b1;
            prev_valid = o_cfg_tvalid;
        end
        checks++; if (!found) begin errors++; $display("FAIL ab_reach: dwell of sweep 3 not seen, sweep_cnt %0d", o_sweep_cnt); end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checks++; if (o_cfg_tvalid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL ab_dwell: tvalid %b busy %b done %b expected 0 0 0", o_cfg_tvalid, o_busy, o_done); end
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_cfg_tvalid || o_busy || o_done) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ab_stay_idle: %0d active cycles expected 0", bad); end
        // Restart, then abort in the very cycle a handshake would complete on word 120.
        i_start = 1'b1;
        k = 0; found = 1'b0;
        while (k < 200 && !found) begin
            @(negedge clk);
            k++;
            i_start = 1'b0;
            if (o_cfg_tvalid && k == 2) begin
                checks++; if (o_cfg_tdata !== 32'd100) begin errors++; $display("FAIL ab_restart: got %0d expected 100", o_cfg_tdata); end
                checks++; if (o_sweep_cnt !== 16'd0) begin errors++; $display("FAIL ab_cnt_clear: got %0d expected 0", o_sweep_cnt); end
            end
            if (o_cfg_tvalid && o_cfg_tdata == 32'd120) begin
                found = 1'b1;
                i_abort = 1'b1;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL ab_reach2: word 120 not seen after restart"); end
        @(negedge clk);
        i_abort = 1'b0;
        checks++; if (o_cfg_tvalid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL ab_handshake: tvalid %b busy %b done %b expected 0 0 0", o_cfg_tvalid, o_busy, o_done); end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_cfg_tvalid || o_busy || o_done) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ab_stay_idle2: %0d active cycles expected 0", bad); end
        run_sweep(2'd0, 32'd50, 32'd70, 32'd10, 16'd0, 16'd1, 1'b0, 100);
        checks++; if (obs_q.size() < 1 || obs_q[0] != 50 || first_valid != 2) begin errors++; $display("FAIL ab_new_start: first word %0d at cycle %0d expected 50 at 2", (obs_q.size() > 0) ? obs_q[0] : -1, first_valid); end
    endtask

    task automatic test_random();
        logic [1:0]  m;
        logic [31:0] lo, hi, st;
        logic [15:0] dw, rp;
        bit bp;
        for (int it = 0; it < 8; it++) begin
            m  = 2'($urandom_range(0, 3));
            lo = 32'($urandom_range(0, 100000));
            hi = lo + 32'($urandom_range(0, 120));
            st = 32'($urandom_range(5, 60));
            dw = 16'($urandom_range(0, 3));
            rp = 16'($urandom_range(1, 3));
            bp = 1'($urandom_range(0, 1));
            run_sweep(m, lo, hi, st, dw, rp, bp, 8000);
            build_expected(int'(m), longint'(lo), longint'(hi), longint'(st), int'(rp));
            checks++; if (timed_out) begin errors++; $display("FAIL rnd%0d_timeout: no o_done within budget", it); end
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d words expected %0d", it, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++; if (obs_q[i] !== exp_q[i] || obs_idx_q[i] != exp_idx_q[i]) begin errors++; $display("FAIL rnd%0d_word%0d: got %0d idx %0d expected %0d idx %0d", it, i, obs_q[i], obs_idx_q[i], exp_q[i], exp_idx_q[i]); end
            end
            checks++; if (stable_bad != 0 || done_cnt != 1 || o_sweep_cnt !== rp) begin errors++; $display("FAIL rnd%0d_end: unstable %0d done %0d sweep_cnt %0d expected 0 1 %0d", it, stable_bad, done_cnt, o_sweep_cnt, rp); end
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        i_mode = 2'd2; i_start_freq = 32'd10; i_stop_freq = 32'd90; i_step_freq = 32'd10;
        i_dwell = 16'd1; i_repeat = 16'd0; i_cfg_tready = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (o_cfg_tvalid !== 1'b0 || o_busy !== 1'b0 || o_cfg_tdata !== 32'd0 || o_step_idx !== 16'd0) begin errors++; $display("FAIL rst_mid: tvalid %b busy %b tdata %0d idx %0d expected all 0", o_cfg_tvalid, o_busy, o_cfg_tdata, o_step_idx); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_up();
        test_overshoot();
        test_triangle();
        test_backpressure_repeat();
        test_reject();
        test_abort();
        test_random();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
